vram_read_arbiter: RTL and testbench
====================================

Name: vram_read_arbiter

Overview:
- Shares the single read port of one GPU memory (tile, attribute or color) between two requesters.
- The pixel renderer is the high-priority requester and issues reads every cycle during active video.
- The CPU readback path, fed by the bus interface, is the low-priority requester.
- A starvation limiter guarantees the CPU gets a slot within a bounded number of cycles. One instance sits in front of each memory's read port.

Parameters:
ADDRESS_WIDTH, 12, memory address width (11 for tile, 12 for attribute, 4 for color)
DATA_WIDTH, 8, memory data width
STARVE_LIMIT, 8, max denied cycles for a pending CPU read before it is forced through; legal range >= 1

Ports:
clk  input  1  system clock (100 MHz domain)
reset  input  1  synchronous, active-high reset
render_req  input  1  renderer read request, level, valid this cycle
render_addr  input  ADDRESS_WIDTH  renderer read address
render_stall  output  1  renderer request not served this cycle; renderer holds req/addr
render_valid  output  1  render_data valid (read issued previous cycle)
render_data  output  DATA_WIDTH  passthrough of mem_read_data
cpu_req  input  1  single-cycle CPU read request pulse
cpu_addr  input  ADDRESS_WIDTH  CPU read address, sampled with cpu_req
cpu_busy  output  1  CPU request pending or in flight
cpu_valid  output  1  one-cycle pulse: cpu_data updated
cpu_data  output  DATA_WIDTH  last CPU read result, held until next completion
mem_read_enable  output  1  to memory read_enable
mem_read_addr  output  ADDRESS_WIDTH  to memory read_addr
mem_read_data  input  DATA_WIDTH  from memory read_data; registered memory, valid one cycle after enable

Behaviour:
- All state updates on posedge clk. reset is sampled synchronously, active-high, and overrides all other inputs.
- Reset values: state=IDLE, pending addr=0, starve counter=0, render_valid=0, cpu_valid=0, cpu_busy=0, cpu_data=0.
- Counter width is $clog2(STARVE_LIMIT+1).
- Reset mid-operation drops any pending or in-flight CPU read. No cpu_valid is produced for it.
- States:
  - IDLE: no CPU work. cpu_req=1 latches cpu_addr into the pending register, clears the counter, and moves to PENDING.
  - PENDING: the CPU read is granted when render_req=0 or counter==STARVE_LIMIT. On grant, go to ISSUED. Otherwise the counter increments, saturating at STARVE_LIMIT.
  - ISSUED: memory output valid this cycle. cpu_data<=mem_read_data, cpu_valid=1 next cycle, go to IDLE.
- Grant mux is combinational in the current cycle:
  - mem_read_enable = render_req OR cpu_grant.
  - mem_read_addr = pending addr when cpu_grant, else render_addr.
- render_stall = render_req AND cpu_grant. This is asserted only on a forced starvation slot.
- render_valid <= render_req AND NOT render_stall. render_data = mem_read_data, combinational.
- cpu_busy = (state != IDLE). It is deasserted in the cycle cpu_valid is high.
- cpu_req while cpu_busy=1 is ignored. Pending addr is unchanged and no error is flagged; the CPU driver polls busy.
- The CPU is never granted in the cycle cpu_req is sampled.
- Latency: CPU request at cycle N is issued at N+1 at the earliest, and cpu_valid/cpu_data appear at N+3. A render request at N produces render_valid at N+1.
- Worst-case CPU latency under continuous render_req: STARVE_LIMIT+3 cycles.
- At most one CPU read is outstanding. Render and CPU are never both issued in one cycle.

Test Plan:
- Render only: render_req=1 with addr 0x100..0x103 on consecutive cycles, memory preloaded -> render_valid=1 from the next cycle and render_data matches each address in order; render_stall never asserted.
- CPU only, render idle: cpu_req pulse addr 0x100 (contents 0xaa) at cycle N -> cpu_busy=1 at N+1, mem_read_addr=0x100 at N+1, cpu_valid pulse and cpu_data=0xaa at N+3, cpu_busy=0 at N+3.
- Starvation, STARVE_LIMIT=4, render_req held 1: CPU read of 0x002 is forced on the 5th PENDING cycle -> render_stall=1 exactly that cycle; render_valid=0 the following cycle; cpu_data = contents of 0x002 at request+7; render reads resume unchanged afterwards.
- Gap insertion: render_req drops for one cycle while the CPU is pending -> CPU is issued in that gap with no render_stall.
- Dropped request: second cpu_req (addr 0x005) while busy -> ignored; the first read's data is returned and no second cpu_valid occurs.
- Reset mid-operation: assert reset in the ISSUED cycle -> no cpu_valid pulse; cpu_data=0, cpu_busy=0, render_valid=0 after reset; a new cpu_req completes normally.

Source files
------------

// File: rtl/vram_read_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vram_read_arbiter_if
//  Description : Render, CPU and memory read-port signals of one arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vram_read_arbiter_if #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 8
);
    logic                     render_req;
    logic [ADDRESS_WIDTH-1:0] render_addr;
    logic                     render_stall;
    logic                     render_valid;
    logic [DATA_WIDTH-1:0]    render_data;
    logic                     cpu_req;
    logic [ADDRESS_WIDTH-1:0] cpu_addr;
    logic                     cpu_busy;
    logic                     cpu_valid;
    logic [DATA_WIDTH-1:0]    cpu_data;
    logic                     mem_read_enable;
    logic [ADDRESS_WIDTH-1:0] mem_read_addr;
    logic [DATA_WIDTH-1:0]    mem_read_data;

    // Arbiter side
    modport slave (
        input  render_req, render_addr, cpu_req, cpu_addr, mem_read_data,
        output render_stall, render_valid, render_data,
               cpu_busy, cpu_valid, cpu_data,
               mem_read_enable, mem_read_addr
    );

    // Requester / memory side
    modport master (
        output render_req, render_addr, cpu_req, cpu_addr, mem_read_data,
        input  render_stall, render_valid, render_data,
               cpu_busy, cpu_valid, cpu_data,
               mem_read_enable, mem_read_addr
    );
endinterface
`default_nettype wire

// File: rtl/vram_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_read_arbiter
//  Description : Shares one VRAM read port between the renderer (priority)
//                and a CPU readback path with a starvation limiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_read_arbiter #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int STARVE_LIMIT  = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    vram_read_arbiter_if.slave bus
);
    localparam int                c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_ISSUED  = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic                     w_accept;
    logic                     w_cpu_grant;
    logic                     w_render_stall;
    logic [ADDRESS_WIDTH-1:0] r_pend_addr;
    logic [c_cnt_w-1:0]       r_starve_cnt;
    logic                     r_render_valid;
    logic                     r_cpu_valid;
    logic [DATA_WIDTH-1:0]    r_cpu_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A request is never granted in the cycle it is accepted: IDLE only latches.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_cpu_grant  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    w_accept     = 1'b1;
                    w_state_next = S_PENDING;
                end
            end
            S_PENDING: begin
                if (!bus.render_req || (r_starve_cnt == c_limit)) begin
                    w_cpu_grant  = 1'b1;
                    w_state_next = S_ISSUED;
                end
            end
            S_ISSUED: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_render_stall = bus.render_req && w_cpu_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_addr    <= '0;
            r_starve_cnt   <= '0;
            r_render_valid <= 1'b0;
            r_cpu_valid    <= 1'b0;
            r_cpu_data     <= '0;
        end else begin
            r_render_valid <= bus.render_req && !w_render_stall;
            r_cpu_valid    <= (r_state == S_ISSUED);
            if (r_state == S_ISSUED) begin
                r_cpu_data <= bus.mem_read_data;
            end
            if (w_accept) begin
                r_pend_addr  <= bus.cpu_addr;
                r_starve_cnt <= '0;
            end else if ((r_state == S_PENDING) && !w_cpu_grant &&
                         (r_starve_cnt != c_limit)) begin
                r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
            end
        end
    end

    assign bus.mem_read_enable = bus.render_req || w_cpu_grant;
    assign bus.mem_read_addr   = w_cpu_grant ? r_pend_addr : bus.render_addr;
    assign bus.render_stall    = w_render_stall;
    assign bus.render_valid    = r_render_valid;
    assign bus.render_data     = bus.mem_read_data;
    assign bus.cpu_busy        = (r_state != S_IDLE);
    assign bus.cpu_valid       = r_cpu_valid;
    assign bus.cpu_data        = r_cpu_data;

endmodule
`default_nettype wire

// File: tb/tb_vram_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_read_arbiter
//  Description : Directed self-checking bench for vram_read_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_read_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int SL = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    vram_read_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    vram_read_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .STARVE_LIMIT  (SL)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preloaded memory contents, with 0x100 holding 0xaa
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (a == 12'h100) return 8'haa;
        return a[7:0] ^ {a[11:8], 4'h9};
    endfunction

    // Registered memory: data valid one cycle after enable
    always @(posedge clk) begin
        if (bus.mem_read_enable) bus.mem_read_data <= mem_val(bus.mem_read_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.render_req = 1'b0; bus.render_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_addr = '0;
        bus.mem_read_data = '0;
        tick(); tick();
        reset = 1'b0;
        #2;
        checks++;
        if (bus.cpu_busy !== 1'b0) begin failures++; $display("FAIL reset_cpu_busy got=%0b exp=0", bus.cpu_busy); end
        checks++;
        if (bus.cpu_valid !== 1'b0) begin failures++; $display("FAIL reset_cpu_valid got=%0b exp=0", bus.cpu_valid); end
        checks++;
        if (bus.cpu_data !== 8'h00) begin failures++; $display("FAIL reset_cpu_data got=%02h exp=00", bus.cpu_data); end
        checks++;
        if (bus.render_valid !== 1'b0) begin failures++; $display("FAIL reset_render_valid got=%0b exp=0", bus.render_valid); end
        checks++;
        if (bus.mem_read_enable !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%0b exp=0", bus.mem_read_enable); end
        tick();
    endtask

    task automatic test_render_only();
        logic [AW-1:0] a;
        for (int i = 0; i < 5; i++) begin
            a = 12'h100 + AW'(i);
            bus.render_req  = (i < 4);
            bus.render_addr = a;
            #2;
            if (i < 4) begin
                checks++;
                if (bus.mem_read_addr !== a || bus.mem_read_enable !== 1'b1) begin
                    failures++; $display("FAIL render_mem_addr i=%0d got=%03h/%0b exp=%03h/1", i, bus.mem_read_addr, bus.mem_read_enable, a);
                end
            end
            checks++;
            if (bus.render_stall !== 1'b0) begin failures++; $display("FAIL render_stall i=%0d got=%0b exp=0", i, bus.render_stall); end
            if (i > 0) begin
                checks++;
                if (bus.render_valid !== 1'b1) begin failures++; $display("FAIL render_valid i=%0d got=%0b exp=1", i, bus.render_valid); end
                checks++;
                if (bus.render_data !== mem_val(a - 12'h1)) begin
                    failures++; $display("FAIL render_data i=%0d got=%02h exp=%02h", i, bus.render_data, mem_val(a - 12'h1));
                end
            end
            tick();
        end
        #2;
        checks++;
        if (bus.render_valid !== 1'b0) begin failures++; $display("FAIL render_valid_drop got=%0b exp=0", bus.render_valid); end
        tick();
    endtask

    task automatic test_cpu_only();
        bus.render_req = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_addr = 12'h100;
        #2;
        checks++;
        if (bus.mem_read_enable !== 1'b0) begin failures++; $display("FAIL cpu_same_cycle_grant got=%0b exp=0", bus.mem_read_enable); end
        tick();
        bus.cpu_req = 1'b0; bus.cpu_addr = 12'hfff;
        #2;
        checks++;
        if (bus.cpu_busy !== 1'b1) begin failures++; $display("FAIL cpu_busy_n1 got=%0b exp=1", bus.cpu_busy); end
        checks++;
        if (bus.mem_read_enable !== 1'b1 || bus.mem_read_addr !== 12'h100) begin
            failures++; $display("FAIL cpu_issue_n1 got=%0b/%03h exp=1/100", bus.mem_read_enable, bus.mem_read_addr);
        end
        tick();
        #2;
        checks++;
        if (bus.cpu_busy !== 1'b1 || bus.cpu_valid !== 1'b0) begin
            failures++; $display("FAIL cpu_n2 busy/valid got=%0b/%0b exp=1/0", bus.cpu_busy, bus.cpu_valid);
        end
        tick();
        #2;
        checks++;
        if (bus.cpu_valid !== 1'b1) begin failures++; $display("FAIL cpu_valid_n3 got=%0b exp=1", bus.cpu_valid); end
        checks++;
        if (bus.cpu_data !== 8'haa) begin failures++; $display("FAIL cpu_data_n3 got=%02h exp=aa", bus.cpu_data); end
        checks++;
        if (bus.cpu_busy !== 1'b0) begin failures++; $display("FAIL cpu_busy_n3 got=%0b exp=0", bus.cpu_busy); end
        tick();
        #2;
        checks++;
        if (bus.cpu_valid !== 1'b0 || bus.cpu_data !== 8'haa) begin
            failures++; $display("FAIL cpu_n4 valid/data got=%0b/%02h exp=0/aa", bus.cpu_valid, bus.cpu_data);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic [AW-1:0] ra;
        logic [AW-1:0] prev_ra;
        logic          prev_issued;
        logic          exp_stall;
        logic [AW-1:0] exp_addr;
        ra = 12'h200; prev_ra = '0; prev_issued = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.cpu_req     = (k == 0);
            bus.cpu_addr    = (k == 0) ? 12'h002 : 12'h0ff;
            bus.render_req  = 1'b1;
            bus.render_addr = ra;
            #2;
            exp_stall = (k == SL + 1);
            exp_addr  = exp_stall ? 12'h002 : ra;
            checks++;
            if (bus.render_stall !== exp_stall) begin failures++; $display("FAIL starve_stall k=%0d got=%0b exp=%0b", k, bus.render_stall, exp_stall); end
            checks++;
            if (bus.mem_read_addr !== exp_addr) begin failures++; $display("FAIL starve_mem_addr k=%0d got=%03h exp=%03h", k, bus.mem_read_addr, exp_addr); end
            checks++;
            if (bus.cpu_valid !== (k == SL + 3)) begin failures++; $display("FAIL starve_cpu_valid k=%0d got=%0b exp=%0b", k, bus.cpu_valid, (k == SL + 3)); end
            checks++;
            if (bus.cpu_busy !== (k >= 1 && k <= SL + 2)) begin
                failures++; $display("FAIL starve_cpu_busy k=%0d got=%0b exp=%0b", k, bus.cpu_busy, (k >= 1 && k <= SL + 2));
            end
            if (k >= 1) begin
                checks++;
                if (bus.render_valid !== prev_issued) begin failures++; $display("FAIL starve_render_valid k=%0d got=%0b exp=%0b", k, bus.render_valid, prev_issued); end
                if (prev_issued) begin
                    checks++;
                    if (bus.render_data !== mem_val(prev_ra)) begin
                        failures++; $display("FAIL starve_render_data k=%0d got=%02h exp=%02h", k, bus.render_data, mem_val(prev_ra));
                    end
                end
            end
            if (k == SL + 3) begin
                checks++;
                if (bus.cpu_data !== mem_val(12'h002)) begin failures++; $display("FAIL starve_cpu_data got=%02h exp=%02h", bus.cpu_data, mem_val(12'h002)); end
            end
            prev_issued = !exp_stall;
            prev_ra     = ra;
            if (!exp_stall) ra = ra + 12'h1;
            tick();
        end
        bus.render_req = 1'b0;
        tick();
    endtask

    task automatic test_gap();
        for (int k = 0; k < 5; k++) begin
            bus.cpu_req     = (k == 0);
            bus.cpu_addr    = 12'h010;
            bus.render_req  = (k != 2);
            bus.render_addr = 12'h300 + AW'(k);
            #2;
            checks++;
            if (bus.render_stall !== 1'b0) begin failures++; $display("FAIL gap_stall k=%0d got=%0b exp=0", k, bus.render_stall); end
            if (k == 1 || k == 2 || k == 3) begin
                checks++;
                if (bus.mem_read_addr !== ((k == 2) ? 12'h010 : 12'h300 + AW'(k))) begin
                    failures++; $display("FAIL gap_mem_addr k=%0d got=%03h exp=%03h", k, bus.mem_read_addr, (k == 2) ? 12'h010 : 12'h300 + AW'(k));
                end
            end
            if (k == 4) begin
                checks++;
                if (bus.cpu_valid !== 1'b1 || bus.cpu_data !== mem_val(12'h010)) begin
                    failures++; $display("FAIL gap_cpu_result got=%0b/%02h exp=1/%02h", bus.cpu_valid, bus.cpu_data, mem_val(12'h010));
                end
            end
            tick();
        end
        bus.render_req = 1'b0;
        tick();
    endtask

    task automatic test_dropped();
        int pulses;
        pulses = 0;
        bus.render_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.cpu_req  = (k <= 2);
            bus.cpu_addr = (k == 0) ? 12'h003 : 12'h005;
            #2;
            if (k == 1) begin
                checks++;
                if (bus.mem_read_addr !== 12'h003) begin failures++; $display("FAIL drop_mem_addr got=%03h exp=003", bus.mem_read_addr); end
            end
            if (k == 3) begin
                checks++;
                if (bus.cpu_valid !== 1'b1 || bus.cpu_data !== mem_val(12'h003)) begin
                    failures++; $display("FAIL drop_result got=%0b/%02h exp=1/%02h", bus.cpu_valid, bus.cpu_data, mem_val(12'h003));
                end
            end
            if (k > 3) bus.cpu_req = 1'b0;
            if (bus.cpu_valid) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 1) begin failures++; $display("FAIL drop_valid_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_reset_mid();
        bus.render_req = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_addr = 12'h006;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        reset = 1'b1;
        bus.render_req = 1'b1; bus.render_addr = 12'h300;
        #2;
        checks++;
        if (bus.cpu_busy !== 1'b1) begin failures++; $display("FAIL rstmid_issued_busy got=%0b exp=1", bus.cpu_busy); end
        tick();
        reset = 1'b0;
        bus.render_req = 1'b0;
        #2;
        checks++;
        if (bus.cpu_valid !== 1'b0) begin failures++; $display("FAIL rstmid_cpu_valid got=%0b exp=0", bus.cpu_valid); end
        checks++;
        if (bus.cpu_busy !== 1'b0) begin failures++; $display("FAIL rstmid_cpu_busy got=%0b exp=0", bus.cpu_busy); end
        checks++;
        if (bus.cpu_data !== 8'h00) begin failures++; $display("FAIL rstmid_cpu_data got=%02h exp=00", bus.cpu_data); end
        checks++;
        if (bus.render_valid !== 1'b0) begin failures++; $display("FAIL rstmid_render_valid got=%0b exp=0", bus.render_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            #2;
            checks++;
            if (bus.cpu_valid !== 1'b0) begin failures++; $display("FAIL rstmid_late_valid k=%0d got=%0b exp=0", k, bus.cpu_valid); end
        end
        bus.cpu_req = 1'b1; bus.cpu_addr = 12'h007;
        tick();
        bus.cpu_req = 1'b0;
        tick(); tick();
        #2;
        checks++;
        if (bus.cpu_valid !== 1'b1 || bus.cpu_data !== mem_val(12'h007)) begin
            failures++; $display("FAIL rstmid_new_read got=%0b/%02h exp=1/%02h", bus.cpu_valid, bus.cpu_data, mem_val(12'h007));
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_render_only();
        test_cpu_only();
        test_starvation();
        test_gap();
        test_dropped();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
